debug_control_unit: RTL
=======================

# debug_control_unit

Sequencer between the UART debug link and the MIPS pipeline. It takes bytes from the UART receiver, assembles little-endian 32-bit instructions and writes them to instruction memory until the halt opcode arrives. It then runs the CPU in continuous or step-by-step mode, gating it with a clock enable. After every step, and at halt, it reports PC and cycle count back through the UART transmitter.

## Interface
- LEN, 32, instruction/data word width
- ADDR_LEN, 10, instruction memory address width (words)
- HALT_OPCODE, 6'b111111, opcode in bits [31:26] that terminates programming and stops execution

- CLK100MHZ  in  1  system clock
- SWITCH_RESET  in  1  asynchronous, active-low reset
- rx_done  in  1  one-cycle pulse: rx_data valid
- rx_data  in  8  received byte
- tx_start  out  1  level request to transmit tx_data; held until tx_done
- tx_data  out  8  byte to transmit
- tx_done  in  1  one-cycle pulse: current byte sent
- imem_wr_en  out  1  one-cycle instruction memory write strobe
- imem_wr_addr  out  ADDR_LEN  word address
- imem_wr_data  out  LEN  assembled instruction
- cpu_reset  out  1  active-high pipeline reset, held while idle or programming
- cpu_enable  out  1  pipeline clock enable
- cpu_halt  in  1  halt instruction reached writeback
- cpu_pc  in  LEN  current PC
- dbg_state  out  3  current state encoding, for LEDs

## Operation
- Commands: START 0x01, CONTINUOUS 0x02, STEP_MODE 0x03, REPROGRAM 0x05, STEP 0x06. Unlisted bytes are ignored in every state except PROGRAM.
- IDLE: cpu_reset=1. START goes to PROGRAM with addr=0, byte_idx=0, cycle_count=0.
- PROGRAM: each rx byte goes into word[8*byte_idx +: 8]; byte 0 is bits [7:0].
  - After the 4th byte: imem_wr_en pulses for one cycle with the current addr and word, then addr increments.
  - If word[31:26]==HALT_OPCODE, or addr was 2^ADDR_LEN-1 when written, go to WAIT_MODE. There is no address wrap.
- WAIT_MODE: cpu_reset=1.
  - CONTINUOUS: go to RUN_CONT.
  - STEP_MODE: go to STEP_WAIT.
  - REPROGRAM: go to PROGRAM (addr, byte_idx and cycle_count cleared).
  - Entering RUN_CONT or STEP_WAIT releases cpu_reset.
- RUN_CONT: cpu_enable=1; cycle_count increments every enabled cycle. cpu_halt high goes to REPORT with return state DONE.
- STEP_WAIT: cpu_enable=0.
  - STEP: go to STEP_EXEC.
  - REPROGRAM: go to PROGRAM with cpu_reset=1.
  - cpu_halt high: go to REPORT, return state DONE.
- STEP_EXEC: exactly one cycle with cpu_enable=1, cycle_count++, then REPORT with return state STEP_WAIT.
- REPORT:
  - On entry, latch cpu_pc and cycle_count.
  - Send 8 bytes: PC LSB first, then count LSB first.
  - tx_start stays high across bytes. tx_data advances on each tx_done. tx_start drops on the 8th tx_done, then go to the return state.
  - rx bytes are dropped.
- DONE: cpu_enable=0, cpu_reset=0. REPROGRAM or START goes to PROGRAM.
- cycle_count is LEN bits and wraps modulo 2^LEN.

## Timing
- Reset values:
  - cpu_reset=1
  - all other outputs 0
  - state IDLE
  - addr, byte_idx, cycle_count all 0
- All outputs are registered.
- imem_wr_en asserts on the cycle after the rx_done of the 4th byte.
- cpu_enable changes on the edge after its causing event:
  - rises on the edge after the CONTINUOUS rx_done;
  - falls on the edge after cpu_halt is sampled high.
- Simultaneous events:
  - cpu_halt together with a STEP rx_done in STEP_WAIT: halt wins and the STEP is dropped.
  - rx_done together with tx_done in REPORT: the tx_done is processed and the rx byte is discarded.
- Reset mid-operation (e.g. mid-REPORT or mid-word): tx_start and imem_wr_en drop asynchronously, and the partial word is discarded.

## Structure
- Shared include debug_defs.vh holds:
  - command constants;
  - state localparams: IDLE, PROGRAM, WAIT_MODE, RUN_CONT, STEP_WAIT, STEP_EXEC, REPORT, DONE (3-bit);
  - HALT_OPCODE default.
- Sub-module debug_report_tx: 8-byte serializer owning the tx_start/tx_data/tx_done handshake. It takes a 64-bit payload plus a start pulse and returns a done pulse.

## Test plan
- Reset release: cpu_reset=1, cpu_enable=0, tx_start=0, dbg_state=IDLE; bytes 0x02 and 0x06 are ignored.
- Programming:
  - Stimulus: 0x01, then 78 56 34 12, then 00 00 00 FC.
  - Response: write addr0=0x12345678, write addr1=0xFC000000, state WAIT_MODE, cpu_reset still 1.
- Continuous run:
  - Stimulus: 0x02, cpu_halt asserted after 5 enabled cycles, cpu_pc=0x00000014.
  - Response: tx bytes 14 00 00 00 05 00 00 00; cpu_enable low; DONE.
- Step mode:
  - Stimulus: 0x03, then 0x06 twice.
  - Response: two single-cycle cpu_enable pulses; two 8-byte reports with count 1 and 2; back in STEP_WAIT.
- Reprogram from STEP_WAIT:
  - Stimulus: 0x05.
  - Response: cpu_reset=1, next word written at addr 0, subsequent report count restarts at 1.
- Async reset asserted after the 3rd tx_done in REPORT: tx_start=0 immediately, state IDLE, no further tx bytes.

Source files
------------

// File: rtl/debug_control_unit_pkg.sv
// Shared definitions for the UART debug sequencer: command bytes, FSM state
// encoding (also driven onto the LEDs) and the default halt opcode.
package debug_control_unit_pkg;

    // Command bytes received over the debug link
    localparam logic [7:0] CmdStart      = 8'h01;
    localparam logic [7:0] CmdContinuous = 8'h02;
    localparam logic [7:0] CmdStepMode   = 8'h03;
    localparam logic [7:0] CmdReprogram  = 8'h05;
    localparam logic [7:0] CmdStep       = 8'h06;

    // Opcode in bits [31:26] that ends programming and stops execution
    localparam logic [5:0] DefaultHaltOpcode = 6'b111111;

    // Encodings are fixed because dbg_state exposes them on the LEDs
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StProgram  = 3'd1,
        StWaitMode = 3'd2,
        StRunCont  = 3'd3,
        StStepWait = 3'd4,
        StStepExec = 3'd5,
        StReport   = 3'd6,
        StDone     = 3'd7
    } dbg_state_e;

endpackage

// File: rtl/debug_report_tx.sv
// Serializes a NumBytes-byte payload, LSB first, onto the UART transmitter
// handshake. tx_start_o is held high across all bytes; tx_data_o advances on
// each tx_done_i and tx_start_o drops on the last one, when done_o pulses.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         one-cycle pulse: latch payload_i and begin sending
//   payload_i       bytes to send, byte 0 in bits [7:0]
//   done_o          one-cycle pulse (combinational) on the final tx_done_i
//   tx_start_o      registered transmit request level
//   tx_data_o       registered byte to transmit
//   tx_done_i       one-cycle pulse: current byte has been sent
module debug_report_tx #(
    parameter int unsigned NumBytes = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [8*NumBytes-1:0]   payload_i,
    output logic                    done_o,
    output logic                    tx_start_o,
    output logic [7:0]              tx_data_o,
    input  logic                    tx_done_i
);

    localparam int unsigned IdxW = $clog2(NumBytes);

    logic [8*NumBytes-1:0] payload_q, payload_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  last;

    assign last   = (idx_q == IdxW'(NumBytes - 1));
    assign done_o = tx_start_q && tx_done_i && last;

    always_comb begin
        payload_d  = payload_q;
        idx_d      = idx_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        if (start_i) begin
            payload_d  = payload_i;
            idx_d      = '0;
            tx_start_d = 1'b1;
            tx_data_d  = payload_i[7:0];
        end else if (tx_start_q && tx_done_i) begin
            if (last) begin
                tx_start_d = 1'b0;
            end else begin
                idx_d     = idx_q + 1'b1;
                tx_data_d = payload_q[8*idx_d +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload_q  <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            payload_q  <= payload_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/debug_control_unit.sv
// Sequencer between the UART debug link and the MIPS pipeline. Assembles
// little-endian instructions from received bytes into instruction memory,
// then runs the CPU continuously or one cycle per STEP command, and reports
// {cycle_count, PC} as 8 bytes after every step and at halt.
//
// Ports:
//   CLK100MHZ, SWITCH_RESET   clock, asynchronous active-low reset
//   rx_done, rx_data          received byte strobe and data
//   tx_start, tx_data, tx_done  transmitter handshake (level request)
//   imem_wr_en/addr/data      instruction memory write port
//   cpu_reset, cpu_enable     pipeline reset (active high) and clock enable
//   cpu_halt, cpu_pc          pipeline status
//   dbg_state                 current state encoding for LEDs
module debug_control_unit
    import debug_control_unit_pkg::*;
#(
    parameter int unsigned LEN         = 32,
    parameter int unsigned ADDR_LEN    = 10,
    parameter logic [5:0]  HALT_OPCODE = DefaultHaltOpcode
) (
    input  logic                CLK100MHZ,
    input  logic                SWITCH_RESET,
    input  logic                rx_done,
    input  logic [7:0]          rx_data,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    output logic                imem_wr_en,
    output logic [ADDR_LEN-1:0] imem_wr_addr,
    output logic [LEN-1:0]      imem_wr_data,
    output logic                cpu_reset,
    output logic                cpu_enable,
    input  logic                cpu_halt,
    input  logic [LEN-1:0]      cpu_pc,
    output logic [2:0]          dbg_state
);

    dbg_state_e          state_q, state_d;
    dbg_state_e          ret_q, ret_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [LEN-1:0]      word_q, word_d;
    logic [LEN-1:0]      count_q, count_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
    logic [LEN-1:0]      wr_data_q, wr_data_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                cpu_enable_q, cpu_enable_d;

    logic [LEN-1:0]      word_next;
    logic                enter_prog;
    logic                rpt_start;
    logic                rpt_done;
    logic [2*LEN-1:0]    rpt_payload;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        enter_prog = 1'b0;
        rpt_start  = 1'b0;

        word_next = word_q;
        word_next[8*byte_idx_q +: 8] = rx_data;

        unique case (state_q)
            StIdle: begin
                if (rx_done && rx_data == CmdStart) enter_prog = 1'b1;
            end
            StProgram: begin
                // Every byte is data here, including command values
                if (rx_done) begin
                    word_d     = word_next;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_next;
                        addr_d    = addr_q + 1'b1;
                        // Stop at halt or at the last word; no address wrap
                        if (word_next[LEN-1 -: 6] == HALT_OPCODE ||
                            addr_q == {ADDR_LEN{1'b1}}) begin
                            state_d = StWaitMode;
                        end
                    end
                end
            end
            StWaitMode: begin
                if (rx_done) begin
                    if (rx_data == CmdContinuous) state_d = StRunCont;
                    else if (rx_data == CmdStepMode) state_d = StStepWait;
                    else if (rx_data == CmdReprogram) enter_prog = 1'b1;
                end
            end
            StRunCont: begin
                // The halting cycle is not counted
                if (cpu_halt) begin
                    state_d   = StReport;
                    ret_d     = StDone;
                    rpt_start = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StStepWait: begin
                // Halt takes priority over a coincident STEP
                if (cpu_halt) begin
                    state_d   = StReport;
                    ret_d     = StDone;
                    rpt_start = 1'b1;
                end else if (rx_done) begin
                    if (rx_data == CmdStep) state_d = StStepExec;
                    else if (rx_data == CmdReprogram) enter_prog = 1'b1;
                end
            end
            StStepExec: begin
                count_d   = count_q + 1'b1;
                state_d   = StReport;
                ret_d     = StStepWait;
                rpt_start = 1'b1;
            end
            StReport: begin
                if (rpt_done) state_d = ret_q;
            end
            StDone: begin
                if (rx_done && (rx_data == CmdReprogram || rx_data == CmdStart)) begin
                    enter_prog = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_prog) begin
            state_d    = StProgram;
            addr_d     = '0;
            byte_idx_d = '0;
            count_d    = '0;
        end

        // Latched by the serializer only when rpt_start is high
        rpt_payload = {count_d, cpu_pc};

        cpu_reset_d  = state_d inside {StIdle, StProgram, StWaitMode};
        cpu_enable_d = state_d inside {StRunCont, StStepExec};
    end

    always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
        if (!SWITCH_RESET) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            count_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            count_q      <= count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_enable_q <= cpu_enable_d;
        end
    end

    debug_report_tx #(
        .NumBytes (2 * LEN / 8)
    ) u_report_tx (
        .clk_i      (CLK100MHZ),
        .rst_ni     (SWITCH_RESET),
        .start_i    (rpt_start),
        .payload_i  (rpt_payload),
        .done_o     (rpt_done),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_done_i  (tx_done)
    );

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_reset    = cpu_reset_q;
    assign cpu_enable   = cpu_enable_q;
    assign dbg_state    = state_q;

endmodule
